// File: rtl/udma_i2c_slave.sv
// rtl/udma_i2c_slave.sv - I2C target with 7-bit address match and byte streams
// Oversampled SCL/SDA, START/STOP detection, NACK/0xFF-fill flow control, no clock stretching.
module udma_i2c_slave #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cfg_en_i,
   input  logic [6:0] cfg_addr_i,
   output logic [7:0] data_rx_o,
   output logic       data_rx_valid_o,
   input  logic       data_rx_ready_i,
   input  logic [7:0] data_tx_i,
   input  logic       data_tx_valid_i,
   output logic       data_tx_ready_o,
   output logic       busy_o,
   output logic       err_o,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_oe
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_d, sda_d;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;
   logic [2:0]             bit_cnt;
   logic                   full;
   logic [7:0]             shift;
   logic [7:0]             tx_byte;
   logic [7:0]             tx_next;
   logic                   rw;
   logic                   addr_match;

   assign sda_o      = 1'b0;
   assign scl_s      = scl_sync[SYNC_STAGES-1];
   assign sda_s      = sda_sync[SYNC_STAGES-1];
   assign scl_rise   = scl_s & ~scl_d;
   assign scl_fall   = ~scl_s & scl_d;
   // START/STOP demand SCL high in both samples, so they never coincide with an SCL edge
   assign start_det  = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det   = scl_s & scl_d & ~sda_d & sda_s;
   assign tx_next    = data_tx_valid_i ? data_tx_i : UNDERRUN_BYTE;
   // address 0 (general call) is deliberately never matched
   assign addr_match = (shift[7:1] == cfg_addr_i) && (shift[7:1] != 7'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i || !cfg_en_i) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || !cfg_en_i) begin
         state           <= IDLE;
         sda_oe          <= 1'b0;
         data_rx_o       <= 8'h00;
         data_rx_valid_o <= 1'b0;
         data_tx_ready_o <= 1'b0;
         busy_o          <= 1'b0;
         err_o           <= 1'b0;
         bit_cnt         <= 3'd0;
         full            <= 1'b0;
         shift           <= 8'h00;
         tx_byte         <= 8'h00;
         rw              <= 1'b0;
      end else begin
         data_rx_valid_o <= 1'b0;
         data_tx_ready_o <= 1'b0;
         err_o           <= 1'b0;
         if (stop_det) begin
            state   <= IDLE;
            sda_oe  <= 1'b0;
            busy_o  <= 1'b0;
         end else if (start_det) begin
            state   <= ADDR;
            sda_oe  <= 1'b0;
            busy_o  <= 1'b0;
            bit_cnt <= 3'd0;
            full    <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               ADDR, WR_DATA: begin
                  if (scl_rise) begin
                     shift   <= {shift[6:0], sda_s};
                     full    <= (bit_cnt == 3'd7);
                     bit_cnt <= bit_cnt + 3'd1;
                  end else if (scl_fall && full) begin
                     full <= 1'b0;
                     if (state == ADDR) begin
                        rw <= shift[0];
                        if (addr_match) begin
                           sda_oe <= 1'b1;
                           state  <= ADDR_ACK;
                        end else begin
                           state  <= WAIT_STOP;
                        end
                     end else begin
                        if (data_rx_ready_i) begin
                           data_rx_o       <= shift;
                           data_rx_valid_o <= 1'b1;
                           sda_oe          <= 1'b1;
                        end else begin
                           sda_oe <= 1'b0;
                           err_o  <= 1'b1;
                        end
                        state <= WR_ACK;
                     end
                  end
               end
               ADDR_ACK, RD_ACK: begin
                  if (state == RD_ACK && scl_rise && sda_s) begin
                     busy_o <= 1'b0;
                     state  <= WAIT_STOP;
                  end else if (scl_fall) begin
                     busy_o  <= 1'b1;
                     bit_cnt <= 3'd0;
                     full    <= 1'b0;
                     if (state == ADDR_ACK && !rw) begin
                        sda_oe <= 1'b0;
                        state  <= WR_DATA;
                     end else begin
                        tx_byte         <= tx_next;
                        sda_oe          <= ~tx_next[7];
                        data_tx_ready_o <= data_tx_valid_i;
                        err_o           <= ~data_tx_valid_i;
                        state           <= RD_DATA;
                     end
                  end
               end
               WR_ACK: begin
                  if (scl_fall) begin
                     sda_oe <= 1'b0;
                     state  <= WR_DATA;
                  end
               end
               RD_DATA: begin
                  if (scl_fall) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        sda_oe <= 1'b0;
                        state  <= RD_ACK;
                     end else begin
                        sda_oe  <= ~tx_byte[6];
                        tx_byte <= {tx_byte[6:0], 1'b0};
                     end
                  end
               end
               WAIT_STOP: sda_oe <= 1'b0;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_udma_i2c_slave.sv
// tb/tb_udma_i2c_slave.sv - directed bus-level bench for udma_i2c_slave
// A bench-side I2C master drives SCL/SDA; the open-drain line is modelled as a wired-AND.
module tb_udma_i2c_slave;

   localparam int Q = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_en = 1'b1;
   logic [6:0] cfg_addr = 7'h50;
   logic [7:0] data_rx_o;
   logic       data_rx_valid_o;
   logic       data_rx_ready = 1'b1;
   logic [7:0] data_tx;
   logic       data_tx_valid = 1'b1;
   logic       data_tx_ready_o;
   logic       busy_o, err_o, sda_o, sda_oe;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_line;

   logic [7:0] tx_tab [8];
   int         tx_idx = 0;
   int         tx_cnt = 0;
   int         err_cnt = 0;
   logic       oe_seen = 1'b0;
   logic [7:0] rx_q [$];

   int n_vec = 0;
   int n_err = 0;

   logic       ack;
   logic [7:0] b;

   assign sda_line = sda_m & ~sda_oe;
   assign data_tx  = tx_tab[tx_idx];

   always #5 clk = ~clk;

   udma_i2c_slave #(.SYNC_STAGES(2), .UNDERRUN_BYTE(8'hFF)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_addr_i(cfg_addr),
      .data_rx_o(data_rx_o), .data_rx_valid_o(data_rx_valid_o), .data_rx_ready_i(data_rx_ready),
      .data_tx_i(data_tx), .data_tx_valid_i(data_tx_valid), .data_tx_ready_o(data_tx_ready_o),
      .busy_o(busy_o), .err_o(err_o), .scl_i(scl_m), .sda_i(sda_line),
      .sda_o(sda_o), .sda_oe(sda_oe)
   );

   always @(negedge clk) begin
      if (data_rx_valid_o) rx_q.push_back(data_rx_o);
      if (data_tx_ready_o) begin
         tx_cnt++;
         tx_idx++;
      end
      if (err_o) err_cnt++;
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clr();
      @(negedge clk);
      rx_q.delete();
      tx_cnt  = 0;
      err_cnt = 0;
      oe_seen = 1'b0;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic wr_bit(input logic v);
      sda_m = v;    wq();
      scl_m = 1'b1; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic rd_bit(output logic v);
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      v = sda_line;
      scl_m = 1'b0; wq();
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic a);
      logic v;
      for (int i = 7; i >= 0; i--) wr_bit(d[i]);
      rd_bit(v);
      a = ~v;
   endtask

   task automatic rd_byte(input logic give_ack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) rd_bit(d[i]);
      wr_bit(~give_ack);
   endtask

   initial begin
      tx_tab[0] = 8'h5A; tx_tab[1] = 8'hC3; tx_tab[2] = 8'h96; tx_tab[3] = 8'h00;
      for (int i = 4; i < 8; i++) tx_tab[i] = 8'hEE;

      repeat (4) @(negedge clk);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_sda_o", sda_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_rx_data", data_rx_o, 0);
      check("rst_rx_valid", data_rx_valid_o, 0);
      check("rst_tx_ready", data_tx_ready_o, 0);
      check("rst_err", err_o, 0);
      rst = 1'b0;
      wq();

      // write 0x3C, 0x81 to own address
      clr();
      i2c_start();
      wr_byte(8'hA0, ack); check("w_addr_ack", ack, 1);
      check("w_busy", busy_o, 1);
      wr_byte(8'h3C, ack); check("w_d0_ack", ack, 1);
      wr_byte(8'h81, ack); check("w_d1_ack", ack, 1);
      check("w_rx_cnt", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         check("w_rx0", rx_q[0], 8'h3C);
         check("w_rx1", rx_q[1], 8'h81);
      end
      i2c_stop();
      check("w_busy_after_stop", busy_o, 0);

      // foreign address 0x51
      clr();
      i2c_start();
      wr_byte(8'hA2, ack); check("x_addr_nack", ack, 0);
      wr_byte(8'h55, ack); check("x_data_ignored", ack, 0);
      check("x_oe_never", oe_seen, 0);
      check("x_rx_cnt", rx_q.size(), 0);
      check("x_busy", busy_o, 0);
      i2c_stop();

      // read two bytes, ACK then NACK
      clr();
      i2c_start();
      wr_byte(8'hA1, ack); check("r_addr_ack", ack, 1);
      rd_byte(1'b1, b); check("r_byte0", b, 8'h5A);
      check("r_busy_mid", busy_o, 1);
      rd_byte(1'b0, b); check("r_byte1", b, 8'hC3);
      check("r_tx_cnt", tx_cnt, 2);
      check("r_sda_released", sda_oe, 0);
      check("r_busy_after_nack", busy_o, 0);
      i2c_stop();

      // read underrun
      clr();
      data_tx_valid = 1'b0;
      i2c_start();
      wr_byte(8'hA1, ack); check("u_addr_ack", ack, 1);
      rd_byte(1'b0, b); check("u_byte", b, 8'hFF);
      check("u_err_cnt", err_cnt, 1);
      check("u_tx_cnt", tx_cnt, 0);
      i2c_stop();
      data_tx_valid = 1'b1;

      // write overflow
      clr();
      data_rx_ready = 1'b0;
      i2c_start();
      wr_byte(8'hA0, ack); check("o_addr_ack", ack, 1);
      wr_byte(8'h77, ack); check("o_data_nack", ack, 0);
      check("o_err_cnt", err_cnt, 1);
      check("o_rx_cnt", rx_q.size(), 0);
      i2c_stop();
      data_rx_ready = 1'b1;

      // repeated START after a partial data byte
      clr();
      i2c_start();
      wr_byte(8'hA0, ack); check("rs_addr_ack", ack, 1);
      for (int i = 0; i < 4; i++) wr_bit(1'b1);
      i2c_start();
      wr_byte(8'hA1, ack); check("rs_raddr_ack", ack, 1);
      rd_byte(1'b0, b); check("rs_byte", b, 8'h96);
      check("rs_rx_cnt", rx_q.size(), 0);
      i2c_stop();

      // reset in the middle of a read byte of zeros
      clr();
      i2c_start();
      wr_byte(8'hA1, ack); check("mr_addr_ack", ack, 1);
      for (int i = 0; i < 3; i++) rd_bit(ack);
      check("mr_oe_driving", sda_oe, 1);
      check("mr_rx_hold", data_rx_o, 8'h81);
      rst = 1'b1;
      @(negedge clk);
      check("mr_sda_oe", sda_oe, 0);
      check("mr_busy", busy_o, 0);
      check("mr_rx_data", data_rx_o, 0);
      check("mr_err", err_o, 0);
      rst = 1'b0;
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/udma_i2c_slave.md
Name: udma_i2c_slave

Overview:
- I2C target (responder) for the uDMA peripheral subsystem; the far end of the bus driven by the uDMA I2C master.
- Oversamples SCL/SDA on the peripheral clock, detects START/STOP, and matches a programmable 7-bit address.
- Master-write bytes go out on an 8-bit valid/ready RX stream; master-read bytes are taken from an 8-bit valid/ready TX stream.
- No clock stretching: SCL is never driven. Flow control is by NACK on writes and 0xFF fill on reads.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on scl_i/sda_i (minimum 2).
- UNDERRUN_BYTE, 8'hFF, byte sent on a master read when data_tx_valid_i is low.

Ports:
- clk_i  in  1  peripheral clock; must be at least 8x SCL frequency.
- rst_i  in  1  synchronous, active-high reset.
- cfg_en_i  in  1  target enable; 0 forces IDLE and releases SDA.
- cfg_addr_i  in  7  own 7-bit address; must be static while busy_o=1.
- data_rx_o  out  8  byte written by the master.
- data_rx_valid_o  out  1  one-cycle pulse; data_rx_o valid.
- data_rx_ready_i  in  1  sink can accept a byte.
- data_tx_i  in  8  byte to return on a master read.
- data_tx_valid_i  in  1  data_tx_i available.
- data_tx_ready_o  out  1  one-cycle pulse; data_tx_i consumed.
- busy_o  out  1  addressed: from address ACK until STOP, repeated START, or master NACK.
- err_o  out  1  one-cycle pulse on TX underrun or RX overflow (NACKed write byte).
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_o  out  1  tied 0 (open-drain).
- sda_oe  out  1  1 = pull SDA low.

Behaviour:
Reset and synchronization
- Reset (rst_i=1 at a clk_i edge) and cfg_en_i=0 give the same result:
  - state=IDLE.
  - sda_oe=0, sda_o=0.
  - data_rx_valid_o=0, data_tx_ready_o=0, busy_o=0, err_o=0, data_rx_o=0.
  - Synchronizer flops preset to 1.
- Event detection on synchronized signals, with one extra delayed copy:
  - SCL rise = 0->1; SCL fall = 1->0.
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
- STOP in any state -> IDLE, SDA released.
- START in any state (including repeated START mid-byte) -> ADDR with bit counter=0.

States
- IDLE: wait for START.
- ADDR:
  - Shift SDA in MSB first on each SCL rise.
  - After 8 bits, on the SCL fall: if byte[7:1]==cfg_addr_i, assert sda_oe -> ADDR_ACK; else -> WAIT_STOP.
- ADDR_ACK: on the next SCL fall, release SDA and set busy_o=1.
  - R/W=0 -> WR_DATA.
  - R/W=1 -> load a TX byte (rule below), drive its MSB -> RD_DATA.
- WR_DATA: shift 8 bits on SCL rises. On the SCL fall after bit 8:
  - data_rx_ready_i=1: data_rx_o=byte, data_rx_valid_o pulse (same cycle), sda_oe=1 (ACK) -> WR_ACK.
  - data_rx_ready_i=0: byte dropped, sda_oe=0 (NACK), err_o pulse -> WR_ACK.
- WR_ACK: on the next SCL fall, release SDA -> WR_DATA.
- TX byte load:
  - data_tx_valid_i=1: capture data_tx_i, pulse data_tx_ready_o.
  - data_tx_valid_i=0: use UNDERRUN_BYTE, pulse err_o.
- RD_DATA: sda_oe = ~current_bit. Advance to the next bit on each SCL fall. After the 8th bit's SCL fall, sda_oe=0 -> RD_ACK.
- RD_ACK: sample SDA on the SCL rise.
  - 0 (ACK): on the SCL fall, load the next TX byte -> RD_DATA.
  - 1 (NACK): busy_o=0 -> WAIT_STOP.
- WAIT_STOP: SDA released; leaves only on STOP or START.

Timing rules
- SDA changes only in the cycle of a detected SCL fall; never while SCL is high.
- Bit counter is 3 bits and wraps 7->0 at each byte boundary.
- SCL rise and START/STOP never coincide in the same cycle: START/STOP require SCL stable high.
- General call (address 0) is not supported; it is treated as a mismatch.

Test Plan:
- cfg_addr_i=0x50. Master writes addr 0xA0, data 0x3C, 0x81, then STOP, data_rx_ready_i=1 -> ACK on all 3 bytes; data_rx_valid_o pulses twice with 0x3C then 0x81; busy_o 1->0 at STOP.
- Master writes to addr 0x51 (byte 0xA2) -> sda_oe never asserted; no RX pulses; state WAIT_STOP until STOP.
- Master reads from 0x50 (0xA1), data_tx_i presents 0x5A then 0xC3, master ACKs the first and NACKs the second -> bus sees 0x5A, 0xC3; data_tx_ready_o pulses twice; SDA released after the NACK.
- Read with data_tx_valid_i=0 -> bus byte 0xFF; err_o one pulse; data_tx_ready_o stays 0.
- Write byte 0x77 with data_rx_ready_i=0 -> NACK on the 9th clock; err_o pulse; no data_rx_valid_o.
- Repeated START after write addr 0xA0 + 4 data bits, then 0xA1 read -> partial byte discarded; read proceeds normally. Separately, rst_i mid-byte -> all outputs at reset values and sda_oe=0 next cycle.
